// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b fetch path.
package lc3b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [15:0] WORD_BYTES       = 16'd2;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch sequencer: reads instruction words, hands them to decode
// over a valid/accept handshake and keeps the PC register loaded with the next address.
module fetch_unit
    import lc3b_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_accept,
    output logic [15:0] pc_in,
    output logic        pc_load,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [15:0]  next_addr_q, next_addr_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic [15:0]  ir_q, ir_d;
    logic         ir_valid_q, ir_valid_d;
    logic [15:0]  pc_in_q, pc_in_d;
    logic         pc_load_q, pc_load_d;
    logic         fault_q, fault_d;
    logic         first_q, first_d;   // first IDLE after reset still owes the PC a RESET_PC load
    logic [15:0]  addr_inc;

    assign addr_inc = mem_addr_q + WORD_BYTES;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        pc_in_d     = pc_in_q;
        pc_load_d   = 1'b0;
        fault_d     = fault_q;
        first_d     = first_q;

        case (state_q)
            IDLE: begin
                mem_addr_d = next_addr_q;
                first_d    = 1'b0;
                if (first_q) begin
                    pc_load_d = 1'b1;
                    pc_in_d   = RESET_PC;
                end
                if (next_addr_q[0]) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    ir_d        = mem_rdata;
                    ir_valid_d  = 1'b1;
                    next_addr_d = addr_inc;
                    pc_in_d     = addr_inc;
                    pc_load_d   = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (ir_accept) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            FAULT: begin
                ir_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A taken branch overrides everything above, including a read completing this cycle.
        if (redirect && state_q != FAULT) begin
            next_addr_d = redirect_addr;
            pc_in_d     = redirect_addr;
            pc_load_d   = 1'b1;
            ir_valid_d  = 1'b0;
            fault_d     = fault_q;
            state_d     = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            next_addr_q <= RESET_PC;
            mem_addr_q  <= 16'h0000;
            ir_q        <= 16'h0000;
            ir_valid_q  <= 1'b0;
            pc_in_q     <= RESET_PC;
            pc_load_q   <= 1'b0;
            fault_q     <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            pc_in_q     <= pc_in_d;
            pc_load_q   <= pc_load_d;
            fault_q     <= fault_d;
            first_q     <= first_d;
        end
    end

    assign mem_rd   = (state_q == FETCH);
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign pc_in    = pc_in_q;
    assign pc_load  = pc_load_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch transactions plus
// hand-written redirect, wrap, misalignment and reset sequences.
module tb_fetch_unit;

    logic        clock_50;
    logic        reset_n;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_accept;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        fault;

    fetch_unit #(.RESET_PC(16'h3000)) dut (
        .clock_50      (clock_50),
        .reset_n       (reset_n),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_accept     (ir_accept),
        .pc_in         (pc_in),
        .pc_load       (pc_load),
        .fault         (fault)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] rdata;
        int          wait_cycles;
        int          accept_delay;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_ir"}, ir, e.ir);
            check({name, "_pc_in"}, pc_in, e.pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hA5A5, 3, 0, 16'h3002, 16'h3004};
        vecs[1] = '{16'h0F0F, 0, 5, 16'h3004, 16'h3006};
        vecs[2] = '{16'hFFFF, 1, 2, 16'h3006, 16'h3008};
        vecs[3] = '{16'h0000, 0, 0, 16'h3008, 16'h300A};

        reset_n = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
        mem_rdata = 16'h0000; mem_ready = 1'b0; ir_accept = 1'b0;
        step(); step();
        reset_n = 1'b1;

        // Cycle 0: reset values.
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_ir", ir, 16'h0000);
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_pc_in", pc_in, 16'h3000);
        check("rst_pc_load", pc_load, 1'b0);
        check("rst_fault", fault, 1'b0);

        // Cycle 1: first fetch, PC loaded with RESET_PC.
        step();
        check("c1_mem_addr", mem_addr, 16'h3000);
        check("c1_mem_rd", mem_rd, 1'b1);
        check("c1_pc_load", pc_load, 1'b1);
        check("c1_pc_in", pc_in, 16'h3000);
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        sb.push_back('{16'h1234, 16'h3002});
        step();
        mem_ready = 1'b0;
        check("c2_ir_valid", ir_valid, 1'b1);
        check("c2_pc_load", pc_load, 1'b1);
        sb_check("c2");
        ir_accept = 1'b1;
        step();
        ir_accept = 1'b0;
        check("c3_ir_valid", ir_valid, 1'b0);
        check("c3_mem_rd", mem_rd, 1'b0);
        check("c3_pc_load", pc_load, 1'b0);
        step();

        // Table-driven transactions; each starts on the first FETCH cycle.
        for (int v = 0; v < 4; v++) begin
            check($sformatf("v%0d_mem_rd", v), mem_rd, 1'b1);
            check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].exp_addr);
            check($sformatf("v%0d_pc_load_entry", v), pc_load, 1'b0);
            for (int w = 0; w < vecs[v].wait_cycles; w++) begin
                ir_accept = 1'b1;   // ignored while nothing is valid
                step();
                check($sformatf("v%0d_w%0d_mem_rd", v, w), mem_rd, 1'b1);
                check($sformatf("v%0d_w%0d_mem_addr", v, w), mem_addr, vecs[v].exp_addr);
                check($sformatf("v%0d_w%0d_ir_valid", v, w), ir_valid, 1'b0);
                check($sformatf("v%0d_w%0d_pc_load", v, w), pc_load, 1'b0);
            end
            ir_accept = 1'b0;
            mem_ready = 1'b1; mem_rdata = vecs[v].rdata;
            sb.push_back('{vecs[v].rdata, vecs[v].exp_pc});
            step();
            mem_ready = 1'b0;
            check($sformatf("v%0d_ir_valid", v), ir_valid, 1'b1);
            check($sformatf("v%0d_pc_load", v), pc_load, 1'b1);
            sb_check($sformatf("v%0d", v));
            for (int h = 0; h < vecs[v].accept_delay; h++) begin
                mem_ready = 1'b1; mem_rdata = 16'hDEAD;   // ignored outside FETCH
                step();
                check($sformatf("v%0d_h%0d_ir", v, h), ir, vecs[v].rdata);
                check($sformatf("v%0d_h%0d_ir_valid", v, h), ir_valid, 1'b1);
                check($sformatf("v%0d_h%0d_mem_rd", v, h), mem_rd, 1'b0);
                check($sformatf("v%0d_h%0d_pc_load", v, h), pc_load, 1'b0);
            end
            mem_ready = 1'b0;
            ir_accept = 1'b1;
            step();
            ir_accept = 1'b0;
            check($sformatf("v%0d_idle_ir_valid", v), ir_valid, 1'b0);
            check($sformatf("v%0d_idle_mem_rd", v), mem_rd, 1'b0);
            step();
        end

        // Redirect in the same cycle as mem_ready: data dropped.
        check("rd_pre_mem_addr", mem_addr, 16'h300A);
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        redirect = 1'b1; redirect_addr = 16'h4000;
        step();
        mem_ready = 1'b0; redirect = 1'b0;
        check("rd_ir_valid", ir_valid, 1'b0);
        check("rd_pc_in", pc_in, 16'h4000);
        check("rd_pc_load", pc_load, 1'b1);
        check("rd_mem_rd", mem_rd, 1'b0);
        step();
        check("rd_next_mem_addr", mem_addr, 16'h4000);
        check("rd_next_mem_rd", mem_rd, 1'b1);
        check("rd_next_pc_load", pc_load, 1'b0);
        check("rd_next_ir_valid", ir_valid, 1'b0);

        // Redirect to 0xFFFE, increment wraps to 0x0000.
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect = 1'b0;
        check("wrap_pc_in_redir", pc_in, 16'hFFFE);
        step();
        check("wrap_mem_addr", mem_addr, 16'hFFFE);
        mem_ready = 1'b1; mem_rdata = 16'h5A5A;
        sb.push_back('{16'h5A5A, 16'h0000});
        step();
        mem_ready = 1'b0;
        check("wrap_pc_load", pc_load, 1'b1);
        sb_check("wrap");
        ir_accept = 1'b1;
        step();
        ir_accept = 1'b0;
        step();
        check("wrap_next_mem_addr", mem_addr, 16'h0000);
        check("wrap_next_mem_rd", mem_rd, 1'b1);

        // Misaligned redirect: FAULT two cycles later, sticky until reset.
        redirect = 1'b1; redirect_addr = 16'h4001;
        step();
        redirect = 1'b0;
        check("mis_r1_fault", fault, 1'b0);
        check("mis_r1_mem_rd", mem_rd, 1'b0);
        check("mis_r1_pc_in", pc_in, 16'h4001);
        step();
        check("mis_r2_fault", fault, 1'b1);
        check("mis_r2_mem_rd", mem_rd, 1'b0);
        redirect = 1'b1; redirect_addr = 16'h5000; mem_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            step();
            redirect = 1'b0; mem_ready = 1'b0;
            check($sformatf("mis_f%0d_fault", f), fault, 1'b1);
            check($sformatf("mis_f%0d_mem_rd", f), mem_rd, 1'b0);
            check($sformatf("mis_f%0d_ir_valid", f), ir_valid, 1'b0);
            check($sformatf("mis_f%0d_pc_load", f), pc_load, 1'b0);
        end

        // One-edge reset clears fault and restarts at RESET_PC.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rst2_fault", fault, 1'b0);
        check("rst2_mem_rd", mem_rd, 1'b0);
        check("rst2_pc_load", pc_load, 1'b0);
        step();
        check("rst2_mem_addr", mem_addr, 16'h3000);
        check("rst2_mem_rd_c1", mem_rd, 1'b1);
        check("rst2_pc_load_c1", pc_load, 1'b1);
        check("rst2_pc_in_c1", pc_in, 16'h3000);

        // Reset with a read pending; late mem_ready ignored.
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h7777;
        check("rst3_mem_rd", mem_rd, 1'b0);
        check("rst3_ir_valid", ir_valid, 1'b0);
        step();
        mem_ready = 1'b0;
        check("rst3_ir", ir, 16'h0000);
        check("rst3_ir_valid_c1", ir_valid, 1'b0);
        check("rst3_pc_load_c1", pc_load, 1'b1);
        check("rst3_pc_in_c1", pc_in, 16'h3000);
        check("rst3_mem_rd_c1", mem_rd, 1'b1);

        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the LC-3b datapath, clocked by `clock_50`. It issues word reads to instruction memory and presents each fetched instruction to decode through a valid/accept handshake. It also drives the PC register's `in`/`load` pair so the PC always holds the incremented (or redirected) address. It sits between the PC register, instruction memory and the decode stage.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `clock_50`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `redirect`  in  1  branch/jump taken; overrides the sequential next address.
- `redirect_addr`  in  16  target address, valid when `redirect`=1.
- `mem_addr`  out  16  instruction read address.
- `mem_rd`  out  1  read request; held until `mem_ready`.
- `mem_rdata`  in  16  read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  read complete this cycle.
- `ir`  out  16  fetched instruction.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_accept`  in  1  decode takes `ir` this cycle.
- `pc_in`  out  16  value for the PC register's `in`.
- `pc_load`  out  1  one-cycle load pulse to the PC register.
- `fault`  out  1  sticky misaligned-fetch flag.

## Operation
- States: IDLE, FETCH, HOLD, FAULT. `mem_rd` = (state==FETCH).
- Reset values (`reset_n`=0 at an edge):
  - State and registers: state=IDLE, next_addr=RESET_PC.
  - Outputs: `mem_addr`=0, `ir`=0, `ir_valid`=0, `pc_in`=RESET_PC, `pc_load`=0, `fault`=0.
- IDLE:
  - Always: `mem_addr`<=next_addr.
  - If next_addr[0]=1, go to FAULT; otherwise go to FETCH.
  - On the first IDLE after reset, also `pc_load`<=1 with `pc_in`=RESET_PC.
- FETCH:
  - Hold `mem_addr` and `mem_rd` stable until `mem_ready`.
  - On `mem_ready`: `ir`<=`mem_rdata`, `ir_valid`<=1, next_addr<=`mem_addr`+2, `pc_in`<=`mem_addr`+2, `pc_load`<=1, go to HOLD.
- HOLD:
  - Hold `ir` and `ir_valid`; no memory request is made.
  - On `ir_accept`: `ir_valid`<=0, go to IDLE.
- FAULT:
  - `fault`=1, `mem_rd`=0, `ir_valid`=0.
  - `redirect` is ignored; only reset exits this state.
- Redirect (any state except FAULT) has priority over `mem_ready` and `ir_accept` in the same cycle:
  - Register updates: next_addr<=`redirect_addr`, `pc_in`<=`redirect_addr`, `pc_load`<=1, `ir_valid`<=0, go to IDLE.
  - Outstanding read: abandoned; same-cycle `mem_rdata` is discarded.
- `pc_load` is high for exactly one cycle per event and is 0 otherwise.
- Arithmetic: address increment is +2 modulo 2^16 (0xFFFE wraps to 0x0000); no carry out.
- Inputs outside their qualifying state are ignored:
  - `mem_ready` outside FETCH.
  - `ir_accept` while `ir_valid`=0.
- Reset mid-operation:
  - The pending read is dropped and `mem_rd` is 0 from the next cycle.
  - A late `mem_ready` is ignored.
  - `pc_load` pulses RESET_PC again.

## Timing
- Reset release at edge E0 → cycle 0 IDLE → cycle 1 FETCH:
  - `mem_addr`=RESET_PC, `mem_rd`=1.
  - `pc_load`=1, `pc_in`=RESET_PC.
- `mem_ready` in cycle n → cycle n+1:
  - `ir_valid`=1.
  - `pc_load`=1, `pc_in`=addr+2.
- `ir_accept` in cycle m → cycle m+1 IDLE (`ir_valid`=0) → cycle m+2 FETCH at next_addr.
- Peak throughput: one instruction per 3 cycles (zero-wait memory, immediate accept).
- Redirect in cycle r → cycle r+1:
  - IDLE, `pc_load`=1.
  - `mem_rd`=0, so there is a one-cycle gap before the new address.
  - Misaligned redirect target: FAULT in cycle r+2.

## Structure
- Package `lc3b_pkg`:
  - `fetch_state_t` enum {IDLE, FETCH, HOLD, FAULT}.
  - `WORD_BYTES`=2.
  - `DEFAULT_RESET_PC`=16'h0000.
- Single module; no sub-module. The +2 incrementer is inline.
- Connection to the PC register: `pc_in`→`in`, `pc_load`→`load`, same `clock_50`.

## Test plan
- Reset, RESET_PC=0x3000, zero-wait memory returning 0x1234:
  - cycle 1: `mem_addr`=0x3000, `mem_rd`=1, `pc_load`=1, `pc_in`=0x3000.
  - cycle 2: `ir`=0x1234, `ir_valid`=1, `pc_in`=0x3002.
  - next fetch at 0x3002.
- `mem_ready` delayed 3 cycles → `mem_rd` and `mem_addr`=0x3000 stable throughout; `ir_valid` rises only the cycle after `mem_ready`; no extra `pc_load`.
- `ir_accept` held low 5 cycles in HOLD → `ir` unchanged, `mem_rd`=0 throughout; fetch of 0x3002 starts 2 cycles after accept.
- `redirect`=1 with `redirect_addr`=0x4000 in the same cycle as `mem_ready` (rdata 0xBEEF):
  - 0xBEEF is dropped and `ir_valid` stays 0.
  - `pc_in`=0x4000 with a `pc_load` pulse.
  - next `mem_addr`=0x4000.
- Redirect to 0xFFFE, fetch completes → `pc_in`=0x0000; next fetch at 0x0000.
- Redirect to 0x4001:
  - `fault`=1 two cycles later; `mem_rd` never asserted.
  - A further redirect is ignored.
  - Asserting `reset_n`=0 for one edge clears `fault` and restarts at RESET_PC.
